// File: rtl/xg_arb_pkg.sv
// Shared types and constants for the 10G MAC TX frame arbiter.
package xg_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 64;

  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

  localparam int KEEP_W = keep_w(DATA_W_DEF);

endpackage

// File: rtl/xg_tx_arbiter_rr_pick.sv
// Round-robin winner selection: rotate requests so last+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             pe;

  always_comb begin
    dbl   = {req, req};
    start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    rot   = dbl[start +: N];
    pe    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pe = i;
    end
    any    = |req;
    winner = IDX_W'((start + pe) % N);
  end

endmodule

// File: rtl/xg_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the MAC wrapper AXI-Stream TX port.
// Handshake: a beat moves when tvalid and tready are both high at clk160m edge.
module xg_tx_arbiter
  import xg_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk160m,
  input  logic                          reset_n,
  input  logic                          mac_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_tdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]          s_tvalid,
  input  logic [NUM_PORTS-1:0]          s_tlast,
  output logic [NUM_PORTS-1:0]          s_tready,
  output logic [DATA_W-1:0]             m_tdata,
  output logic [DATA_W/8-1:0]           m_tkeep,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          frame_done,
  output logic [IDX_W-1:0]              frame_port
);

  localparam int KW = keep_w(DATA_W);

  arb_state_t       state;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             last_beat;

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (s_tvalid),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // Output path is a pure mux: no pipeline stage between source and MAC.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == ST_XFER) begin
      m_tdata           = s_tdata[int'(cur_idx)*DATA_W +: DATA_W];
      m_tkeep           = s_tkeep[int'(cur_idx)*KW +: KW];
      m_tvalid          = s_tvalid[cur_idx];
      m_tlast           = s_tlast[cur_idx];
      s_tready[cur_idx] = m_tready;
    end
  end

  assign last_beat = m_tvalid & m_tready & m_tlast;

  // mac_ready only gates new grants; an in-flight frame always completes.
  always_ff @(posedge clk160m) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      cur_idx    <= '0;
      last_q     <= IDX_W'(NUM_PORTS - 1);
      frame_done <= 1'b0;
      frame_port <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mac_ready && any_req) begin
            grant   <= NUM_PORTS'(1) << winner;
            cur_idx <= winner;
            last_q  <= winner;
            state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            grant      <= '0;
            frame_done <= 1'b1;
            frame_port <= cur_idx;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/xg_tx_arbiter.md
# xg_tx_arbiter

Packet-level round-robin arbiter that shares the single AXI-Stream TX input of the 10G MAC wrapper between `NUM_PORTS` frame sources. It runs in the `clk160m` system domain and feeds the MAC's `axis_tx_*` port. Grants never split a frame. New grants are held off while the MAC wrapper's `ready` output is low.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesting streams, 2..8.
- `DATA_W`, 64: tdata width. tkeep width is `DATA_W/8`.
- `IDX_W`, `$clog2(NUM_PORTS)`: port index width.

Ports:
- `clk160m`, in, 1: system clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `mac_ready`, in, 1: MAC wrapper `ready`. Gates new grants only.
- `s_tdata`, in, `NUM_PORTS*DATA_W`: port p occupies bits `[p*DATA_W +: DATA_W]`.
- `s_tkeep`, in, `NUM_PORTS*DATA_W/8`: per-port byte enables.
- `s_tvalid`, in, `NUM_PORTS`: per-port valid.
- `s_tlast`, in, `NUM_PORTS`: per-port end of frame.
- `s_tready`, out, `NUM_PORTS`: per-port ready.
- `m_tdata`, out, `DATA_W`: to MAC `axis_tx_tdata`.
- `m_tkeep`, out, `DATA_W/8`: to MAC `axis_tx_tkeep`.
- `m_tvalid`, out, 1: to MAC `axis_tx_tvalid`.
- `m_tready`, in, 1: from MAC `axis_tx_tready`.
- `m_tlast`, out, 1: to MAC `axis_tx_tlast`.
- `grant`, out, `NUM_PORTS`: one-hot owner of the output. All zero when idle.
- `frame_done`, out, 1: single-cycle pulse, one cycle after a frame's last beat.
- `frame_port`, out, `IDX_W`: port that completed the frame. Valid while `frame_done` is high.

## Operation
- FSM has two states, IDLE and XFER. Reset state is IDLE.
- **IDLE:**
  - If `mac_ready` is high and any `s_tvalid` is high, pick the winner round-robin, starting at `last+1` (mod `NUM_PORTS`) and searching upward with wrap.
  - On that clock edge, register the winner into `grant`/`cur_idx`, set `last <= winner`, and move to XFER.
  - Otherwise stay in IDLE.
- **XFER:** combinational mux from port `cur_idx`.
  - `m_tdata`, `m_tkeep`, and `m_tlast` come from that port. `m_tvalid = s_tvalid[cur_idx]`.
  - `s_tready[cur_idx] = m_tready`. Every other `s_tready` bit is 0.
  - On a beat with `m_tvalid & m_tready & m_tlast`: go to IDLE, clear `grant`, and on the next cycle assert `frame_done` with `frame_port = cur_idx`.
- `mac_ready` falling during XFER does not abort the frame. The frame completes normally, and no new grant is issued until `mac_ready` is high again.
- A granted source that drops `s_tvalid` mid-frame keeps the grant indefinitely. There is no timeout.
- Outside XFER, `m_tvalid` and all `s_tready` bits are 0. `m_tdata`, `m_tkeep`, and `m_tlast` are driven to 0.
- Single-beat frames (tlast on the first beat) are legal.

## Timing
- Reset values:
  - `grant` = 0, `frame_done` = 0, `frame_port` = 0, `m_tvalid` = 0, `s_tready` = 0.
  - `last` = `NUM_PORTS-1`, so port 0 has the highest priority after reset.
- Grant latency: a request seen in IDLE at cycle n allows the first beat at cycle n+1.
- Inter-frame gap: exactly one IDLE cycle after each last beat. Back-to-back frames therefore have one bubble.
- Output data path has no register stage: `m_*` depends combinationally on `s_*` and `m_tready`. There is no pipeline latency through the mux.
- Simultaneous events:
  - When the last beat and a new request arrive in the same cycle, the new request is arbitrated in the following IDLE cycle. `last` has already been updated to the finished port.
  - When `reset_n` is low at an edge mid-frame, the block returns to IDLE at that edge. The frame is truncated, and the source is responsible for discarding it.

## Structure
- Shared package `xg_arb_pkg` holds:
  - FSM state encoding (IDLE=1'b0, XFER=1'b1);
  - `KEEP_W` = `DATA_W/8`.
- One combinational sub-module, `rr_pick`: inputs are the request vector and `last`; outputs are the winner index and an `any` flag. It rotates, applies a priority-encode, and un-rotates.
- The FSM, grant register, mux, and frame_done logic live in `xg_tx_arbiter`.

## Test plan
- **Port 0 alone:**
  - Stimulus: after reset, port 0 sends a 3-beat frame with tkeep `FF,FF,0F` and `m_tready`=1.
  - Response: grant=`0001` one cycle after tvalid, 3 output beats identical to input, and `frame_done`=1 with `frame_port`=0 on the cycle after the last beat.
- **Round-robin fairness:**
  - Stimulus: all 4 ports continuously offer 2-beat frames.
  - Response: grant order 0,1,2,3,0,…, with exactly one idle cycle between frames.
- **MAC not ready:**
  - Stimulus: `mac_ready`=0 with ports 1 and 2 requesting.
  - Response: no grant and `m_tvalid`=0. When `mac_ready` rises, port 1 is granted first.
- **mac_ready drop mid-frame:**
  - Stimulus: `mac_ready` falls on beat 2 of a 5-beat frame.
  - Response: all 5 beats are delivered and `frame_done` fires. There is no further grant while `mac_ready`=0.
- **Backpressure:**
  - Stimulus: `m_tready` toggles 1,0,0,1 during a 4-beat frame from port 3.
  - Response: `s_tready[3]` mirrors `m_tready`, no beat is lost or duplicated, and the other `s_tready` bits stay 0.
- **Reset mid-frame:**
  - Stimulus: `reset_n` is low for 1 cycle during beat 2.
  - Response: the next cycle shows grant=0 and `m_tvalid`=0. The following arbitration starts from port 0.
